// File: rtl/des_key_schedule_rev.sv
// DES round-subkey generator: one 48-bit subkey per handshake, K16..K1 (pDecrypt=1) or K1..K16.
// First subkey one cycle after key accept; a stalled consumer freezes subkey, round and CD state.
module des_key_schedule_rev #(
  parameter bit pDecrypt = 1'b1
) (
  input  logic        wClk,
  input  logic        wResetN,
  input  logic [0:63] wKey,
  input  logic        wKeyValid,
  output logic        wKeyReady,
  output logic [0:47] wSubKey,
  output logic        wSubKeyValid,
  input  logic        wSubKeyReady,
  output logic [0:3]  wRound,
  output logic        wLast
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit i set when round i+1 shifts by two; the other rounds shift by one.
  localparam logic [0:15] SHIFT2 = 16'b0011_1111_0111_1110;

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (logic [5:0] i = 6'd0; i < 6'd56; i = i + 6'd1) begin
      r[i] = k[6'(PC1_TAB[i] - 1)];
    end
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (logic [5:0] i = 6'd0; i < 6'd48; i = i + 6'd1) begin
      r[i] = cd[6'(PC2_TAB[i] - 1)];
    end
    return r;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] h, input logic two);
    return two ? {h[2:27], h[0:1]} : {h[1:27], h[0]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] h, input logic two);
    return two ? {h[26:27], h[0:25]} : {h[27], h[0:26]};
  endfunction

  state_t      state_q, state_d;
  logic [0:55] cd_q, cd0, cd_load, cd_step, cd_next;
  logic [3:0]  step_q;
  logic [0:47] sub_key_q;
  logic [0:3]  round_q;
  logic        key_take, step_take, seq_done;
  logic        unused_parity;

  assign unused_parity = ^{wKey[7], wKey[15], wKey[23], wKey[31],
                           wKey[39], wKey[47], wKey[55], wKey[63]};

  always_comb begin
    state_d   = state_q;
    key_take  = 1'b0;
    step_take = 1'b0;
    seq_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wKeyValid) begin
          state_d  = RUN;
          key_take = 1'b1;
        end
      end
      RUN: begin
        if (wSubKeyReady) begin
          if (step_q == 4'd15) begin
            state_d  = IDLE;
            seq_done = 1'b1;
          end else begin
            step_take = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decrypt starts from CD0 directly: the 28 total left shifts bring C16/D16 back to C0/D0.
  always_comb begin
    cd0     = pc1(wKey);
    cd_load = pDecrypt ? cd0 : {rotl(cd0[0:27], 1'b0), rotl(cd0[28:55], 1'b0)};
    if (pDecrypt) begin
      cd_step = {rotr(cd_q[0:27], SHIFT2[4'd15 - step_q]),
                 rotr(cd_q[28:55], SHIFT2[4'd15 - step_q])};
    end else begin
      cd_step = {rotl(cd_q[0:27], SHIFT2[step_q + 4'd1]),
                 rotl(cd_q[28:55], SHIFT2[step_q + 4'd1])};
    end
    cd_next = key_take ? cd_load : cd_step;
  end

  always_ff @(posedge wClk) begin
    if (!wResetN) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      step_q    <= '0;
      sub_key_q <= '0;
      round_q   <= '0;
    end else begin
      state_q <= state_d;
      if (key_take) begin
        cd_q      <= cd_next;
        step_q    <= '0;
        sub_key_q <= pc2(cd_next);
        round_q   <= pDecrypt ? 4'd15 : 4'd0;
      end else if (step_take) begin
        cd_q      <= cd_next;
        step_q    <= step_q + 4'd1;
        sub_key_q <= pc2(cd_next);
        round_q   <= pDecrypt ? round_q - 4'd1 : round_q + 4'd1;
      end else if (seq_done) begin
        step_q <= '0;
      end
    end
  end

  assign wKeyReady    = (state_q == IDLE);
  assign wSubKeyValid = (state_q == RUN);
  assign wSubKey      = sub_key_q;
  assign wRound       = round_q;
  assign wLast        = (step_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule_rev.sv
// Directed bench: decrypt and encrypt instances share inputs and are checked against textbook subkeys.
module tb_des_key_schedule_rev;

  logic        wClk = 1'b0;
  logic        wResetN;
  logic [0:63] wKey;
  logic        wKeyValid;
  logic        wSubKeyReady;

  logic        rdy_d, vld_d, last_d, rdy_e, vld_e, last_e;
  logic [0:47] sk_d, sk_e;
  logic [0:3]  rnd_d, rnd_e;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;

  // K1..K16 for KEY_A
  logic [47:0] kref [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 wClk = ~wClk;

  des_key_schedule_rev #(.pDecrypt(1'b1)) dut_dec (
    .wClk(wClk), .wResetN(wResetN), .wKey(wKey), .wKeyValid(wKeyValid),
    .wKeyReady(rdy_d), .wSubKey(sk_d), .wSubKeyValid(vld_d),
    .wSubKeyReady(wSubKeyReady), .wRound(rnd_d), .wLast(last_d)
  );

  des_key_schedule_rev #(.pDecrypt(1'b0)) dut_enc (
    .wClk(wClk), .wResetN(wResetN), .wKey(wKey), .wKeyValid(wKeyValid),
    .wKeyReady(rdy_e), .wSubKey(sk_e), .wSubKeyValid(vld_e),
    .wSubKeyReady(wSubKeyReady), .wRound(rnd_e), .wLast(last_e)
  );

  task automatic load_key(input logic [63:0] k);
    wKey = k;
    wKeyValid = 1'b1;
    @(negedge wClk);
    wKeyValid = 1'b0;
  endtask

  task automatic test_reset;
    logic [54:0] exp_v;
    exp_v = {1'b0, 1'b1, 48'h0, 4'd0, 1'b0};
    checks++;
    if ({vld_d, rdy_d, sk_d, rnd_d, last_d} !== exp_v) begin
      errors++;
      $display("FAIL reset_dec got %h want %h", {vld_d, rdy_d, sk_d, rnd_d, last_d}, exp_v);
    end
    checks++;
    if ({vld_e, rdy_e, sk_e, rnd_e, last_e} !== exp_v) begin
      errors++;
      $display("FAIL reset_enc got %h want %h", {vld_e, rdy_e, sk_e, rnd_e, last_e}, exp_v);
    end
    wResetN = 1'b1;
    @(negedge wClk);
  endtask

  task automatic test_decrypt_order;
    logic [54:0] exp_v;
    wSubKeyReady = 1'b1;
    load_key(KEY_A);
    for (int j = 0; j < 16; j++) begin
      exp_v = {1'b1, 1'b0, kref[15-j], 4'(15 - j), (j == 15)};
      checks++;
      if ({vld_d, rdy_d, sk_d, rnd_d, last_d} !== exp_v) begin
        errors++;
        $display("FAIL dec_order[%0d] got %h want %h", j, {vld_d, rdy_d, sk_d, rnd_d, last_d}, exp_v);
      end
      @(negedge wClk);
    end
    checks++;
    if ({vld_d, rdy_d} !== 2'b01) begin
      errors++;
      $display("FAIL dec_end vld/rdy got %b want 01", {vld_d, rdy_d});
    end
  endtask

  task automatic test_encrypt_order;
    logic [54:0] exp_v;
    wSubKeyReady = 1'b1;
    load_key(KEY_A);
    for (int j = 0; j < 16; j++) begin
      exp_v = {1'b1, 1'b0, kref[j], 4'(j), (j == 15)};
      checks++;
      if ({vld_e, rdy_e, sk_e, rnd_e, last_e} !== exp_v) begin
        errors++;
        $display("FAIL enc_order[%0d] got %h want %h", j, {vld_e, rdy_e, sk_e, rnd_e, last_e}, exp_v);
      end
      @(negedge wClk);
    end
    checks++;
    if ({vld_e, rdy_e, last_e} !== 3'b010) begin
      errors++;
      $display("FAIL enc_end vld/rdy/last got %b want 010", {vld_e, rdy_e, last_e});
    end
  endtask

  task automatic test_parity;
    wSubKeyReady = 1'b1;
    load_key(KEY_P);
    for (int j = 0; j < 16; j++) begin
      checks++;
      if ({sk_d, sk_e} !== {kref[15-j], kref[j]}) begin
        errors++;
        $display("FAIL parity[%0d] got %h %h want %h %h", j, sk_d, sk_e, kref[15-j], kref[j]);
      end
      @(negedge wClk);
    end
  endtask

  task automatic test_backpressure;
    logic [54:0] exp_v;
    wSubKeyReady = 1'b1;
    load_key(KEY_A);
    for (int j = 0; j < 16; j++) begin
      exp_v = {1'b1, 1'b0, kref[15-j], 4'(15 - j), (j == 15)};
      checks++;
      if ({vld_d, rdy_d, sk_d, rnd_d, last_d} !== exp_v) begin
        errors++;
        $display("FAIL bp_seq[%0d] got %h want %h", j, {vld_d, rdy_d, sk_d, rnd_d, last_d}, exp_v);
      end
      if (j == 2) begin
        wSubKeyReady = 1'b0;
        wKey = 64'hFFFF_FFFF_FFFF_FFFF;
        wKeyValid = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge wClk);
          checks++;
          if ({vld_d, rdy_d, sk_d, rnd_d, last_d} !== exp_v) begin
            errors++;
            $display("FAIL bp_hold[%0d] got %h want %h", s, {vld_d, rdy_d, sk_d, rnd_d, last_d}, exp_v);
          end
        end
        wKeyValid = 1'b0;
        wKey = KEY_A;
        wSubKeyReady = 1'b1;
      end
      @(negedge wClk);
    end
    checks++;
    if ({vld_d, rdy_d} !== 2'b01) begin
      errors++;
      $display("FAIL bp_end vld/rdy got %b want 01", {vld_d, rdy_d});
    end
  endtask

  task automatic test_reset_mid;
    logic [54:0] exp_v;
    wSubKeyReady = 1'b1;
    load_key(KEY_A);
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (sk_d !== kref[15-j]) begin
        errors++;
        $display("FAIL rst_pre[%0d] got %h want %h", j, sk_d, kref[15-j]);
      end
      if (j == 6) wResetN = 1'b0;
      @(negedge wClk);
    end
    exp_v = {1'b0, 1'b1, 48'h0, 4'd0, 1'b0};
    checks++;
    if ({vld_d, rdy_d, sk_d, rnd_d, last_d} !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_dec got %h want %h", {vld_d, rdy_d, sk_d, rnd_d, last_d}, exp_v);
    end
    checks++;
    if ({vld_e, rdy_e, sk_e, rnd_e, last_e} !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_enc got %h want %h", {vld_e, rdy_e, sk_e, rnd_e, last_e}, exp_v);
    end
    wResetN = 1'b1;
    load_key(KEY_A);
    checks++;
    if ({vld_d, sk_d, rnd_d, sk_e} !== {1'b1, kref[15], 4'd15, kref[0]}) begin
      errors++;
      $display("FAIL rst_restart got %h %h %h want %h %h f", sk_d, rnd_d, sk_e, kref[15], kref[0]);
    end
    for (int j = 1; j < 16; j++) begin
      @(negedge wClk);
      checks++;
      if ({sk_d, last_d} !== {kref[15-j], (j == 15)}) begin
        errors++;
        $display("FAIL rst_rerun[%0d] got %h %b want %h", j, sk_d, last_d, kref[15-j]);
      end
    end
    @(negedge wClk);
  endtask

  task automatic test_back_to_back;
    wSubKeyReady = 1'b1;
    wKey = KEY_A;
    wKeyValid = 1'b1;
    @(negedge wClk);
    for (int j = 0; j < 16; j++) begin
      checks++;
      if ({vld_d, sk_d, last_d} !== {1'b1, kref[15-j], (j == 15)}) begin
        errors++;
        $display("FAIL b2b_first[%0d] got %b %h %b want %h", j, vld_d, sk_d, last_d, kref[15-j]);
      end
      @(negedge wClk);
    end
    checks++;
    if ({vld_d, rdy_d} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_bubble vld/rdy got %b want 01", {vld_d, rdy_d});
    end
    @(negedge wClk);
    wKeyValid = 1'b0;
    checks++;
    if ({vld_d, sk_d, rnd_d, sk_e} !== {1'b1, kref[15], 4'd15, kref[0]}) begin
      errors++;
      $display("FAIL b2b_second_start got %b %h %h %h want %h %h", vld_d, sk_d, rnd_d, sk_e, kref[15], kref[0]);
    end
    for (int j = 1; j < 16; j++) begin
      @(negedge wClk);
      checks++;
      if ({sk_d, rnd_d} !== {kref[15-j], 4'(15 - j)}) begin
        errors++;
        $display("FAIL b2b_second[%0d] got %h %h want %h", j, sk_d, rnd_d, kref[15-j]);
      end
    end
    @(negedge wClk);
    checks++;
    if ({vld_d, rdy_d, vld_e, rdy_e} !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_end got %b want 0101", {vld_d, rdy_d, vld_e, rdy_e});
    end
  endtask

  initial begin
    wResetN = 1'b0;
    wKey = '0;
    wKeyValid = 1'b0;
    wSubKeyReady = 1'b0;
    repeat (2) @(posedge wClk);
    @(negedge wClk);
    test_reset;
    test_decrypt_order;
    test_encrypt_order;
    test_parity;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
